rmii_rx_gen2: RTL and testbench

Parametrised second-generation RMII receive front end.
- Performs the PHY reset and strap sequence, synchronises CRS_DV/RXD, and detects preamble and SFD.
- Supports 100 Mb/s and 10 Mb/s sampling and assembles dibits into OUT_WIDTH-bit words.
- Reports frame length and error status with an end-of-frame pulse.
- Sits between the PHY pins and the frame buffer/CRC stage.

---
 rtl/rmii_rx_gen2.sv | 254 +++++++++++++++++++++++++
 tb/tb_rmii_rx_gen2.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_rx_gen2.sv
// rmii_rx_gen2: RMII receive front end.
// Runs the PHY reset/strap sequence, synchronises CRS_DV/RXD/RXER, finds the
// preamble and SFD, and assembles dibits into OUT_WIDTH-bit words. Frame
// length and error status are reported with a one-cycle end-of-frame pulse.
// Ports:
//   clk        50 MHz REF_CLK
//   rstn       asynchronous active-low reset
//   speed_10   1 = 10 Mb/s sampling, 0 = 100 Mb/s (taken in IDLE)
//   crsdv_in   CRS_DV pin, carries MODE[2] strap during reset sequence
//   rxd_in     RXD pins, carry MODE[1:0] strap during reset sequence
//   rxerr      RXER pin, carries PHYAD strap during reset sequence
//   intn       nINT pin, carries nINTSEL strap during reset sequence
//   phy_rstn   PHY nRST
//   out        assembled word, first dibit in out[1:0]
//   outclk     one-cycle valid pulse for out
//   done       one-cycle end-of-frame pulse
//   frame_len  complete words in the frame, valid with done
//   err        {err_long, err_align, err_rxer}, valid with done
module rmii_rx_gen2 #(
    parameter int unsigned OUT_WIDTH      = 8,
    parameter int unsigned SYNC_DELAY_LEN = 3,
    parameter int unsigned RESET_SETUP    = 10,
    parameter int unsigned RESET_HOLD     = 5,
    parameter logic [2:0]  STRAP_MODE     = 3'b011,
    parameter logic        STRAP_PHYAD    = 1'b0,
    parameter logic        STRAP_NINTSEL  = 1'b1,
    parameter int unsigned MIN_PREAMBLE   = 4,
    parameter int unsigned MAX_WORDS      = 1522 * 8 / OUT_WIDTH
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               speed_10,
    inout  wire                                crsdv_in,
    inout  wire  [1:0]                         rxd_in,
    inout  wire                                rxerr,
    inout  wire                                intn,
    output logic                               phy_rstn,
    output logic [OUT_WIDTH-1:0]               out,
    output logic                               outclk,
    output logic                               done,
    output logic [$clog2(MAX_WORDS + 1)-1:0]   frame_len,
    output logic [2:0]                         err
);

    localparam int unsigned DIBITS  = OUT_WIDTH / 2;
    localparam int unsigned IDX_W   = (DIBITS > 1) ? $clog2(DIBITS) : 1;
    localparam int unsigned LEN_W   = $clog2(MAX_WORDS + 1);
    localparam int unsigned RST_END = RESET_SETUP + RESET_HOLD;
    localparam int unsigned CNT_W   = $clog2(RST_END + 1);
    localparam int unsigned PRE_W   = $clog2(MIN_PREAMBLE + 1);

    typedef enum logic [2:0] {
        RSTSEQ, IDLE, WAITING, PREAMBLE, RECEIVING, ENDF, DISCARD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [3:0]         phase_q, phase_d;
    logic               spd_q, spd_d;
    logic               crs_prev_q, crs_prev_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OUT_WIDTH-1:0] asm_q, asm_d;
    logic [OUT_WIDTH-1:0] out_d;
    logic               outclk_d, done_d, phy_rstn_d;
    logic [LEN_W-1:0]   len_d;
    logic [2:0]         err_d;

    logic               drive_straps_c;
    logic [3:0]         pin_raw_c;
    logic [3:0]         sync_q [SYNC_DELAY_LEN];
    logic               crsdv_s, rxerr_s;
    logic [1:0]         rxd_s;
    logic               is_10_c, sample_c, dv_c;

    // Strap pins are driven for the whole reset sequence, released afterwards
    assign drive_straps_c = (state_q == RSTSEQ);
    assign crsdv_in = drive_straps_c ? STRAP_MODE[2]   : 1'bz;
    assign rxd_in   = drive_straps_c ? STRAP_MODE[1:0] : 2'bzz;
    assign rxerr    = drive_straps_c ? STRAP_PHYAD     : 1'bz;
    assign intn     = drive_straps_c ? STRAP_NINTSEL   : 1'bz;

    // Own strap values are kept out of the receive path
    assign pin_raw_c = drive_straps_c ? 4'b0000 : {rxerr, rxd_in, crsdv_in};

    // Equal-depth synchroniser for all receive pins keeps them aligned
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(SYNC_DELAY_LEN); i++) sync_q[i] <= 4'b0000;
        end else begin
            sync_q[0] <= pin_raw_c;
            for (int i = 1; i < int'(SYNC_DELAY_LEN); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign crsdv_s = sync_q[SYNC_DELAY_LEN-1][0];
    assign rxd_s   = sync_q[SYNC_DELAY_LEN-1][2:1];
    assign rxerr_s = sync_q[SYNC_DELAY_LEN-1][3];

    // Live speed select in IDLE, latched copy for the rest of the frame
    assign is_10_c  = (state_q == IDLE) ? speed_10 : spd_q;
    assign sample_c = is_10_c ? (phase_q == 4'd4) : 1'b1;

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= RSTSEQ;
            rst_cnt_q  <= '0;
            phase_q    <= '0;
            spd_q      <= 1'b0;
            crs_prev_q <= 1'b0;
            pre_cnt_q  <= '0;
            idx_q      <= '0;
            asm_q      <= '0;
            out        <= '0;
            outclk     <= 1'b0;
            done       <= 1'b0;
            frame_len  <= '0;
            err        <= '0;
            phy_rstn   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            phase_q    <= phase_d;
            spd_q      <= spd_d;
            crs_prev_q <= crs_prev_d;
            pre_cnt_q  <= pre_cnt_d;
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            out        <= out_d;
            outclk     <= outclk_d;
            done       <= done_d;
            frame_len  <= len_d;
            err        <= err_d;
            phy_rstn   <= phy_rstn_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        phase_d    = phase_q;
        spd_d      = spd_q;
        crs_prev_d = crs_prev_q;
        pre_cnt_d  = pre_cnt_q;
        idx_d      = idx_q;
        asm_d      = asm_q;
        out_d      = out;
        outclk_d   = 1'b0;
        done_d     = 1'b0;
        len_d      = frame_len;
        err_d      = err;
        phy_rstn_d = phy_rstn;
        dv_c       = 1'b0;

        // Mod-10 phase held at zero while idle, so it starts on carrier rise
        if (state_q == RSTSEQ || (state_q == IDLE && !crsdv_s)) begin
            phase_d = 4'd0;
        end else if (phase_q == 4'd9) begin
            phase_d = 4'd0;
        end else begin
            phase_d = phase_q + 4'd1;
        end

        if (sample_c) begin
            crs_prev_d = crsdv_s;
        end

        case (state_q)
            RSTSEQ: begin
                rst_cnt_d = rst_cnt_q + 1'b1;
                if (rst_cnt_q == CNT_W'(RESET_SETUP - 1)) phy_rstn_d = 1'b1;
                if (rst_cnt_q == CNT_W'(RST_END)) state_d = IDLE;
            end
            IDLE: begin
                if (sample_c && crsdv_s) begin
                    state_d = WAITING;
                    spd_d   = speed_10;
                    len_d   = '0;
                    err_d   = '0;
                end
            end
            WAITING: begin
                if (sample_c) begin
                    if (!crsdv_s) begin
                        state_d = IDLE;
                    end else if (rxd_s == 2'b01) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = PRE_W'(1);
                    end
                end
            end
            PREAMBLE: begin
                if (sample_c) begin
                    if (!crsdv_s) begin
                        state_d = IDLE;
                    end else begin
                        case (rxd_s)
                            2'b01: begin
                                if (pre_cnt_q < PRE_W'(MIN_PREAMBLE)) pre_cnt_d = pre_cnt_q + 1'b1;
                            end
                            2'b11: begin
                                if (pre_cnt_q >= PRE_W'(MIN_PREAMBLE)) begin
                                    state_d = RECEIVING;
                                    idx_d   = '0;
                                end else begin
                                    state_d = DISCARD;
                                end
                            end
                            default: pre_cnt_d = '0;
                        endcase
                    end
                end
            end
            RECEIVING: begin
                if (sample_c) begin
                    // A CRS_DV toggle still marks a valid dibit; two lows end the frame
                    dv_c = (crsdv_s != crs_prev_q) ? 1'b1 : crsdv_s;
                    if (rxerr_s) err_d[0] = 1'b1;
                    if (dv_c) begin
                        for (int unsigned i = 0; i < DIBITS; i++) begin
                            if (idx_q == IDX_W'(i)) asm_d[2*i +: 2] = rxd_s;
                        end
                        if (idx_q == IDX_W'(DIBITS - 1)) begin
                            idx_d = '0;
                            if (frame_len == LEN_W'(MAX_WORDS)) begin
                                err_d[2] = 1'b1;
                            end else begin
                                out_d    = asm_d;
                                outclk_d = 1'b1;
                                len_d    = frame_len + 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        state_d = ENDF;
                        done_d  = 1'b1;
                        if (idx_q != '0) err_d[1] = 1'b1;
                    end
                end
            end
            ENDF: begin
                state_d = IDLE;
            end
            DISCARD: begin
                if (sample_c && !crsdv_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rmii_rx_gen2.sv
// Directed testbench for rmii_rx_gen2 (OUT_WIDTH=8, MAX_WORDS=2).
// Frames end with the last data dibit carried on the CRS_DV falling toggle,
// followed by CRS_DV low, so the final dibit is still data-valid.
module tb_rmii_rx_gen2;

    localparam int unsigned MAX_WORDS = 2;
    localparam int unsigned LEN_W     = $clog2(MAX_WORDS + 1);

    logic clk = 1'b0;
    logic rstn, speed_10;
    logic tb_en, tb_crsdv, tb_rxerr, tb_intn;
    logic [1:0] tb_rxd;
    wire crsdv_w, rxerr_w, intn_w;
    wire [1:0] rxd_w;
    logic phy_rstn, outclk, done;
    logic [7:0] out;
    logic [LEN_W-1:0] frame_len;
    logic [2:0] err;

    int checks = 0;
    int errors = 0;

    // PHY model drives pins only when enabled
    assign crsdv_w = tb_en ? tb_crsdv : 1'bz;
    assign rxd_w   = tb_en ? tb_rxd   : 2'bzz;
    assign rxerr_w = tb_en ? tb_rxerr : 1'bz;
    assign intn_w  = tb_en ? tb_intn  : 1'bz;

    rmii_rx_gen2 #(.OUT_WIDTH(8), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rstn(rstn), .speed_10(speed_10),
        .crsdv_in(crsdv_w), .rxd_in(rxd_w), .rxerr(rxerr_w), .intn(intn_w),
        .phy_rstn(phy_rstn), .out(out), .outclk(outclk), .done(done),
        .frame_len(frame_len), .err(err)
    );

    always #10 clk = ~clk;

    // Output monitor
    int cyc = 0;
    int oc_total = 0, done_total = 0, overlap_total = 0;
    logic [7:0] out_log [$];
    int oc_time [$];
    logic [LEN_W-1:0] last_len = '0;
    logic [2:0] last_err = '0;
    logic [7:0] tx_bytes [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (outclk) begin
            out_log.push_back(out);
            oc_time.push_back(cyc);
            oc_total <= oc_total + 1;
        end
        if (done) begin
            done_total <= done_total + 1;
            last_len   <= frame_len;
            last_err   <= err;
        end
        if (outclk && done) overlap_total <= overlap_total + 1;
    end

    task automatic drive(input logic crs, input logic [1:0] d, input logic er, input int hold);
        tb_crsdv = crs; tb_rxd = d; tb_rxerr = er;
        repeat (hold) @(negedge clk);
    endtask

    // Preamble, SFD, n_dib dibits of tx_bytes (LSB first), then idle gap
    task automatic send_frame(input int n_pre, input int n_dib, input int err_dibit, input int hold);
        logic [7:0] b;
        for (int i = 0; i < n_pre; i++) drive(1'b1, 2'b01, 1'b0, hold);
        drive(1'b1, 2'b11, 1'b0, hold);
        for (int i = 0; i < n_dib; i++) begin
            b = tx_bytes[i / 4];
            drive(i != n_dib - 1, 2'(b >> (2 * (i % 4))), i == err_dibit, hold);
        end
        drive(1'b0, 2'b00, 1'b0, hold * 12);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (phy_rstn !== 1'b0) begin errors++; $display("FAIL reset_phy_rstn: got %b expected 0", phy_rstn); end
        checks++; if ({out, outclk, done, frame_len, err} !== '0) begin errors++;
            $display("FAIL reset_outputs: got out=%h outclk=%b done=%b len=%0d err=%b expected all 0", out, outclk, done, frame_len, err); end
        rstn = 1'b1;
        repeat (9) @(negedge clk);
        checks++; if (phy_rstn !== 1'b0) begin errors++; $display("FAIL rstseq_phy_low_9: got %b expected 0", phy_rstn); end
        checks++; if ({crsdv_w, rxd_w, rxerr_w, intn_w} !== 5'b0_11_0_1) begin errors++;
            $display("FAIL straps_early: got %b expected 01101", {crsdv_w, rxd_w, rxerr_w, intn_w}); end
        @(negedge clk);
        checks++; if (phy_rstn !== 1'b1) begin errors++; $display("FAIL rstseq_phy_high_10: got %b expected 1", phy_rstn); end
        repeat (5) @(negedge clk);
        checks++; if ({crsdv_w, rxd_w, rxerr_w, intn_w} !== 5'b0_11_0_1) begin errors++;
            $display("FAIL straps_held_15: got %b expected 01101", {crsdv_w, rxd_w, rxerr_w, intn_w}); end
        @(negedge clk);
        tb_crsdv = 1'b0; tb_rxd = 2'b00; tb_rxerr = 1'b1; tb_intn = 1'b0; tb_en = 1'b1;
        #1;
        checks++; if ({crsdv_w, rxd_w, rxerr_w, intn_w} !== 5'b0_00_1_0) begin errors++;
            $display("FAIL straps_released_16: got %b expected 00010", {crsdv_w, rxd_w, rxerr_w, intn_w}); end
        tb_rxerr = 1'b0; tb_intn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic_100;
        int oc0 = oc_total, dn0 = done_total, q0 = out_log.size();
        tx_bytes = {}; tx_bytes.push_back(8'hA5);
        send_frame(7, 4, -1, 1);
        checks++; if (oc_total - oc0 !== 1) begin errors++; $display("FAIL basic_outclk_count: got %0d expected 1", oc_total - oc0); end
        checks++; if (out_log.size() <= q0 || out_log[q0] !== 8'hA5) begin errors++; $display("FAIL basic_out: expected a5, log size %0d", out_log.size() - q0); end
        checks++; if (done_total - dn0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_total - dn0); end
        checks++; if ({last_len, last_err} !== {2'd1, 3'b000}) begin errors++; $display("FAIL basic_len_err: got len=%0d err=%b expected 1 000", last_len, last_err); end
    endtask

    task automatic test_align;
        int oc0 = oc_total, dn0 = done_total;
        tx_bytes = {}; tx_bytes.push_back(8'h1B);
        send_frame(7, 3, -1, 1);
        checks++; if (oc_total - oc0 !== 0) begin errors++; $display("FAIL align_outclk_count: got %0d expected 0", oc_total - oc0); end
        checks++; if (done_total - dn0 !== 1) begin errors++; $display("FAIL align_done_count: got %0d expected 1", done_total - dn0); end
        checks++; if ({last_len, last_err} !== {2'd0, 3'b010}) begin errors++; $display("FAIL align_len_err: got len=%0d err=%b expected 0 010", last_len, last_err); end
    endtask

    task automatic test_short_preamble;
        int oc0 = oc_total, dn0 = done_total, q0;
        tx_bytes = {}; tx_bytes.push_back(8'hA5);
        send_frame(2, 4, -1, 1);
        checks++; if (oc_total - oc0 !== 0 || done_total - dn0 !== 0) begin errors++;
            $display("FAIL short_pre_discard: got outclk=%0d done=%0d expected 0 0", oc_total - oc0, done_total - dn0); end
        oc0 = oc_total; dn0 = done_total; q0 = out_log.size();
        tx_bytes = {}; tx_bytes.push_back(8'h3C);
        send_frame(7, 4, -1, 1);
        checks++; if (oc_total - oc0 !== 1 || out_log.size() <= q0 || out_log[q0] !== 8'h3C) begin errors++;
            $display("FAIL after_discard_out: got %0d words expected one word 3c", oc_total - oc0); end
        checks++; if (done_total - dn0 !== 1 || {last_len, last_err} !== {2'd1, 3'b000}) begin errors++;
            $display("FAIL after_discard_done: got done=%0d len=%0d err=%b expected 1 1 000", done_total - dn0, last_len, last_err); end
    endtask

    task automatic test_preamble_boundary;
        int oc0 = oc_total, dn0 = done_total, q0;
        tx_bytes = {}; tx_bytes.push_back(8'h96);
        send_frame(4, 4, -1, 1);
        checks++; if (oc_total - oc0 !== 0 || done_total - dn0 !== 0) begin errors++;
            $display("FAIL pre4_discard: got outclk=%0d done=%0d expected 0 0", oc_total - oc0, done_total - dn0); end
        oc0 = oc_total; dn0 = done_total; q0 = out_log.size();
        send_frame(5, 4, -1, 1);
        checks++; if (oc_total - oc0 !== 1 || out_log.size() <= q0 || out_log[q0] !== 8'h96) begin errors++;
            $display("FAIL pre5_accept: got %0d words expected one word 96", oc_total - oc0); end
        checks++; if (done_total - dn0 !== 1 || {last_len, last_err} !== {2'd1, 3'b000}) begin errors++;
            $display("FAIL pre5_done: got done=%0d len=%0d err=%b expected 1 1 000", done_total - dn0, last_len, last_err); end
    endtask

    task automatic test_speed_10;
        int oc0 = oc_total, dn0 = done_total, q0 = out_log.size();
        speed_10 = 1'b1;
        tx_bytes = {}; tx_bytes.push_back(8'hA5); tx_bytes.push_back(8'h3C);
        send_frame(7, 8, -1, 10);
        speed_10 = 1'b0;
        checks++; if (oc_total - oc0 !== 2) begin errors++; $display("FAIL s10_outclk_count: got %0d expected 2", oc_total - oc0); end
        checks++; if (out_log.size() < q0 + 2 || out_log[q0] !== 8'hA5 || out_log[q0+1] !== 8'h3C) begin errors++;
            $display("FAIL s10_out: expected a5 3c, log size %0d", out_log.size() - q0); end
        checks++; if (oc_time.size() < q0 + 2 || oc_time[q0+1] - oc_time[q0] !== 40) begin errors++;
            $display("FAIL s10_spacing: got %0d expected 40", (oc_time.size() < q0 + 2) ? -1 : oc_time[q0+1] - oc_time[q0]); end
        checks++; if (done_total - dn0 !== 1 || {last_len, last_err} !== {2'd2, 3'b000}) begin errors++;
            $display("FAIL s10_done: got done=%0d len=%0d err=%b expected 1 2 000", done_total - dn0, last_len, last_err); end
    endtask

    task automatic test_long_rxerr;
        int oc0 = oc_total, dn0 = done_total, q0 = out_log.size();
        tx_bytes = {}; tx_bytes.push_back(8'h3C); tx_bytes.push_back(8'hF0); tx_bytes.push_back(8'h81);
        send_frame(7, 12, 5, 1);
        checks++; if (oc_total - oc0 !== 2) begin errors++; $display("FAIL long_outclk_count: got %0d expected 2", oc_total - oc0); end
        checks++; if (out_log.size() < q0 + 2 || out_log[q0] !== 8'h3C || out_log[q0+1] !== 8'hF0) begin errors++;
            $display("FAIL long_out: expected 3c f0, log size %0d", out_log.size() - q0); end
        checks++; if (done_total - dn0 !== 1) begin errors++; $display("FAIL long_done_count: got %0d expected 1", done_total - dn0); end
        checks++; if ({last_len, last_err} !== {2'd2, 3'b101}) begin errors++; $display("FAIL long_len_err: got len=%0d err=%b expected 2 101", last_len, last_err); end
    endtask

    task automatic test_reset_midframe;
        int dn0 = done_total, oc0, q0;
        tx_bytes = {}; tx_bytes.push_back(8'hA5);
        for (int i = 0; i < 7; i++) drive(1'b1, 2'b01, 1'b0, 1);
        drive(1'b1, 2'b11, 1'b0, 1);
        for (int i = 0; i < 4; i++) drive(1'b1, 2'(tx_bytes[0] >> (2 * i)), 1'b0, 1);
        drive(1'b1, 2'b00, 1'b0, 6);
        checks++; if (frame_len !== 2'd1 || out !== 8'hA5) begin errors++;
            $display("FAIL midframe_pre: got len=%0d out=%h expected 1 a5", frame_len, out); end
        rstn = 1'b0; tb_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({phy_rstn, out, outclk, done, frame_len, err} !== '0) begin errors++;
            $display("FAIL midframe_reset_outputs: got phy=%b out=%h outclk=%b done=%b len=%0d err=%b expected all 0",
                     phy_rstn, out, outclk, done, frame_len, err); end
        rstn = 1'b1;
        repeat (18) @(negedge clk);
        tb_crsdv = 1'b0; tb_rxd = 2'b00; tb_rxerr = 1'b0; tb_en = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (done_total - dn0 !== 0) begin errors++; $display("FAIL midframe_no_done: got %0d expected 0", done_total - dn0); end
        oc0 = oc_total; dn0 = done_total; q0 = out_log.size();
        tx_bytes = {}; tx_bytes.push_back(8'hC3);
        send_frame(7, 4, -1, 1);
        checks++; if (oc_total - oc0 !== 1 || out_log.size() <= q0 || out_log[q0] !== 8'hC3) begin errors++;
            $display("FAIL midframe_recover_out: got %0d words expected one word c3", oc_total - oc0); end
        checks++; if (done_total - dn0 !== 1 || {last_len, last_err} !== {2'd1, 3'b000}) begin errors++;
            $display("FAIL midframe_recover_done: got done=%0d len=%0d err=%b expected 1 1 000", done_total - dn0, last_len, last_err); end
    endtask

    task automatic test_no_overlap;
        checks++; if (overlap_total !== 0) begin errors++; $display("FAIL done_outclk_overlap: got %0d expected 0", overlap_total); end
    endtask

    initial begin
        rstn = 1'b0; speed_10 = 1'b0; tb_en = 1'b0;
        tb_crsdv = 1'b0; tb_rxd = 2'b00; tb_rxerr = 1'b0; tb_intn = 1'b1;
        test_reset;
        test_basic_100;
        test_align;
        test_short_preamble;
        test_preamble_boundary;
        test_speed_10;
        test_long_rxerr;
        test_reset_midframe;
        test_no_overlap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
